// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised FIFO family.
package fifo_pkg;

    // Read-mode selectors for the FWFT parameter
    localparam int MODE_STD  = 0;
    localparam int MODE_FWFT = 1;

    // Ceiling log2, used to size addresses and pointers from DEPTH
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        for (int i = 0; i < 32; i++) begin
            if (remaining > 0) begin
                result++;
                remaining = remaining >> 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Storage array for the FIFO: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; the pointers decide what is valid.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    output logic [DATA_WIDTH-1:0] read_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Store the incoming word at the write address on an accepted write
    always_ff @(posedge clock) begin
        if (write_enable) begin
            mem[write_addr] <= write_data;
        end
    end

    assign read_data = mem[read_addr];

endmodule

// File: rtl/fifo_param_buffer.sv
// Parametrised single-clock FIFO with standard or first-word-fall-through reads,
// registered status flags, fill count, sticky error flags and synchronous flush.
module fifo_param_buffer
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AFULL_LVL  = 12,
    parameter int AEMPTY_LVL = 4,
    parameter int FWFT       = MODE_STD
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    write_Enable,
    input  logic                    read_Enable,
    input  logic [DATA_WIDTH-1:0]   buffer_Input,
    output logic [DATA_WIDTH-1:0]   buffer_Output,
    output logic                    sig_Full,
    output logic                    sig_Empty,
    output logic                    sig_Almost_Full,
    output logic                    sig_Almost_Empty,
    output logic [clog2(DEPTH):0]   fill_Count,
    output logic                    err_Overflow,
    output logic                    err_Underflow
);

    localparam int ADDR_WIDTH = clog2(DEPTH);
    localparam int PTR_WIDTH  = ADDR_WIDTH + 1;

    typedef logic [PTR_WIDTH-1:0] ptr_t;

    localparam ptr_t AFULL_COUNT  = ptr_t'(AFULL_LVL);
    localparam ptr_t AEMPTY_COUNT = ptr_t'(AEMPTY_LVL);

    // Reject illegal configurations at elaboration time
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("fifo_param_buffer: DEPTH must be a power of two and at least 2");
    end
    if (!((AEMPTY_LVL < AFULL_LVL) && (AFULL_LVL <= DEPTH))) begin : g_bad_levels
        $error("fifo_param_buffer: need AEMPTY_LVL < AFULL_LVL <= DEPTH");
    end

    ptr_t                  wr_ptr_q, wr_ptr_d;
    ptr_t                  rd_ptr_q, rd_ptr_d;
    ptr_t                  count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  afull_q, afull_d;
    logic                  aempty_q, aempty_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic [DATA_WIDTH-1:0] out_q, out_d;

    logic                  rd_accept;
    logic                  wr_accept;
    logic                  ram_write;
    logic [DATA_WIDTH-1:0] head_word;

    // A read needs data present; a write needs room, or a read freeing a slot in the same cycle
    assign rd_accept = read_Enable && !empty_q;
    assign wr_accept = write_Enable && (!full_q || rd_accept);
    assign ram_write = wr_accept && !flush && !reset;

    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clock        (clock),
        .write_enable (ram_write),
        .write_addr   (wr_ptr_q[ADDR_WIDTH-1:0]),
        .write_data   (buffer_Input),
        .read_addr    (rd_ptr_q[ADDR_WIDTH-1:0]),
        .read_data    (head_word)
    );

    // Next-state for pointers, count, output register, sticky errors and all status flags
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        out_d    = out_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            out_d    = '0;
        end else begin
            if (rd_accept) begin
                rd_ptr_d = rd_ptr_q + ptr_t'(1);
                if (FWFT == MODE_STD) begin
                    out_d = head_word;
                end
            end
            if (wr_accept) begin
                wr_ptr_d = wr_ptr_q + ptr_t'(1);
            end
            count_d = count_q + ptr_t'(wr_accept) - ptr_t'(rd_accept);
            if (write_Enable && !wr_accept) begin
                ovf_d = 1'b1;
            end
            if (read_Enable && empty_q) begin
                unf_d = 1'b1;
            end
        end

        full_d   = (wr_ptr_d[ADDR_WIDTH-1:0] == rd_ptr_d[ADDR_WIDTH-1:0]) &&
                   (wr_ptr_d[ADDR_WIDTH] != rd_ptr_d[ADDR_WIDTH]);
        empty_d  = (wr_ptr_d == rd_ptr_d);
        afull_d  = (count_d >= AFULL_COUNT);
        aempty_d = (count_d <= AEMPTY_COUNT);
    end

    // State register with synchronous reset taking priority over everything else
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            out_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            out_q    <= out_d;
        end
    end

    assign buffer_Output    = (FWFT == MODE_FWFT) ? (empty_q ? '0 : head_word) : out_q;
    assign sig_Full         = full_q;
    assign sig_Empty        = empty_q;
    assign sig_Almost_Full  = afull_q;
    assign sig_Almost_Empty = aempty_q;
    assign fill_Count       = count_q;
    assign err_Overflow     = ovf_q;
    assign err_Underflow    = unf_q;

endmodule

// File: tb/tb_fifo_param_buffer.sv
// Self-checking bench: one standard-mode and one FWFT-mode FIFO compared against a queue model.
module tb_fifo_param_buffer;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AFL   = 12;
    localparam int AEL   = 4;

    logic          clock = 1'b0;
    logic          reset;

    logic          flush0, we0, re0;
    logic [DW-1:0] din0, dout0;
    logic          full0, empty0, afull0, aempty0, ovf0, unf0;
    logic [4:0]    count0;

    logic          flush1, we1, re1;
    logic [DW-1:0] din1, dout1;
    logic          full1, empty1, afull1, aempty1, ovf1, unf1;
    logic [4:0]    count1;

    int            checks = 0;
    int            errors = 0;

    logic [DW-1:0] model_q [$];
    logic [DW-1:0] model_out;
    logic          model_ovf;
    logic          model_unf;

    // Free-running clock, 10 time units per period
    always #5 clock = ~clock;

    fifo_param_buffer #(
        .DATA_WIDTH (DW), .DEPTH (DEPTH), .AFULL_LVL (AFL), .AEMPTY_LVL (AEL), .FWFT (0)
    ) dut_std (
        .clock (clock), .reset (reset), .flush (flush0),
        .write_Enable (we0), .read_Enable (re0),
        .buffer_Input (din0), .buffer_Output (dout0),
        .sig_Full (full0), .sig_Empty (empty0),
        .sig_Almost_Full (afull0), .sig_Almost_Empty (aempty0),
        .fill_Count (count0), .err_Overflow (ovf0), .err_Underflow (unf0)
    );

    fifo_param_buffer #(
        .DATA_WIDTH (DW), .DEPTH (DEPTH), .AFULL_LVL (AFL), .AEMPTY_LVL (AEL), .FWFT (1)
    ) dut_fwft (
        .clock (clock), .reset (reset), .flush (flush1),
        .write_Enable (we1), .read_Enable (re1),
        .buffer_Input (din1), .buffer_Output (dout1),
        .sig_Full (full1), .sig_Empty (empty1),
        .sig_Almost_Full (afull1), .sig_Almost_Empty (aempty1),
        .fill_Count (count1), .err_Overflow (ovf1), .err_Underflow (unf1)
    );

    // One comparison: counted always, failure counted and reported
    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle into the selected instance, advance the model, then compare every output
    task automatic apply_stimulus(input bit mode, input bit rst, input bit fl,
                                  input bit we, input bit re, input logic [DW-1:0] d);
        bit            was_empty, was_full, do_rd, do_wr;
        int            size;
        logic [DW-1:0] head;
        logic [DW-1:0] exp_out;

        @(negedge clock);
        reset  = rst;
        flush0 = (mode == 0) ? fl : 1'b0;
        we0    = (mode == 0) ? we : 1'b0;
        re0    = (mode == 0) ? re : 1'b0;
        din0   = d;
        flush1 = (mode == 1) ? fl : 1'b0;
        we1    = (mode == 1) ? we : 1'b0;
        re1    = (mode == 1) ? re : 1'b0;
        din1   = d;
        @(posedge clock);
        #1;

        if (rst) begin
            model_q.delete();
            model_out = '0;
            model_ovf = 1'b0;
            model_unf = 1'b0;
        end else if (fl) begin
            model_q.delete();
            model_out = '0;
        end else begin
            was_empty = (model_q.size() == 0);
            was_full  = (model_q.size() == DEPTH);
            do_rd     = re && !was_empty;
            do_wr     = we && (!was_full || do_rd);
            if (re && was_empty) model_unf = 1'b1;
            if (we && !do_wr)    model_ovf = 1'b1;
            if (do_rd) begin
                head = model_q.pop_front();
                if (mode == 0) model_out = head;
            end
            if (do_wr) model_q.push_back(d);
        end

        size = model_q.size();
        if (mode == 0) exp_out = model_out;
        else           exp_out = (size != 0) ? model_q[0] : '0;

        check_output("count",  32'(mode ? count1  : count0),  32'(size));
        check_output("empty",  32'(mode ? empty1  : empty0),  32'(size == 0));
        check_output("full",   32'(mode ? full1   : full0),   32'(size == DEPTH));
        check_output("afull",  32'(mode ? afull1  : afull0),  32'(size >= AFL));
        check_output("aempty", 32'(mode ? aempty1 : aempty0), 32'(size <= AEL));
        check_output("ovf",    32'(mode ? ovf1    : ovf0),    32'(model_ovf));
        check_output("unf",    32'(mode ? unf1    : unf0),    32'(model_unf));
        check_output("dout",   32'(mode ? dout1   : dout0),   32'(exp_out));
    endtask

    // Directed scenarios followed by randomized traffic for both read modes
    initial begin
        reset = 1'b0;
        flush0 = 1'b0; we0 = 1'b0; re0 = 1'b0; din0 = '0;
        flush1 = 1'b0; we1 = 1'b0; re1 = 1'b0; din1 = '0;
        model_out = '0; model_ovf = 1'b0; model_unf = 1'b0;

        $display("[TB] standard mode: reset and idle");
        apply_stimulus(0, 1, 0, 0, 0, 8'h00);
        apply_stimulus(0, 0, 0, 0, 0, 8'h00);

        $display("[TB] standard mode: fill, overflow, drain");
        for (int i = 1; i <= 16; i++) apply_stimulus(0, 0, 0, 1, 0, DW'(i));
        apply_stimulus(0, 0, 0, 1, 0, 8'h11);
        for (int i = 0; i < 16; i++) apply_stimulus(0, 0, 0, 0, 1, 8'h00);

        $display("[TB] standard mode: underflow, sticky across flush");
        apply_stimulus(0, 0, 0, 0, 1, 8'h00);
        apply_stimulus(0, 0, 0, 0, 0, 8'h00);
        apply_stimulus(0, 0, 1, 0, 0, 8'h00);
        apply_stimulus(0, 0, 0, 0, 0, 8'h00);

        $display("[TB] standard mode: full with simultaneous write and read");
        apply_stimulus(0, 1, 0, 0, 0, 8'h00);
        for (int i = 0; i < 16; i++) apply_stimulus(0, 0, 0, 1, 0, DW'($urandom));
        apply_stimulus(0, 0, 0, 1, 1, 8'hAA);
        for (int i = 0; i < 16; i++) apply_stimulus(0, 0, 0, 0, 1, 8'h00);

        $display("[TB] standard mode: pointer wrap at mid fill");
        for (int i = 0; i < 8; i++) apply_stimulus(0, 0, 0, 1, 0, DW'($urandom));
        for (int i = 0; i < 40; i++) apply_stimulus(0, 0, 0, 1, 1, DW'($urandom));
        for (int i = 0; i < 8; i++) apply_stimulus(0, 0, 0, 0, 1, 8'h00);

        $display("[TB] standard mode: random traffic");
        apply_stimulus(0, 1, 0, 0, 0, 8'h00);
        for (int i = 0; i < 400; i++)
            apply_stimulus(0, 0, ($urandom_range(0, 39) == 0), $urandom_range(0, 1),
                           $urandom_range(0, 1), DW'($urandom));

        $display("[TB] fwft mode: fall-through, read to empty, flush");
        apply_stimulus(1, 1, 0, 0, 0, 8'h00);
        apply_stimulus(1, 0, 0, 1, 0, 8'h55);
        apply_stimulus(1, 0, 0, 0, 0, 8'h00);
        apply_stimulus(1, 0, 0, 0, 1, 8'h00);
        for (int i = 0; i < 5; i++) apply_stimulus(1, 0, 0, 1, 0, DW'($urandom));
        apply_stimulus(1, 0, 1, 0, 0, 8'h00);
        apply_stimulus(1, 0, 0, 0, 0, 8'h00);

        $display("[TB] fwft mode: random traffic");
        for (int i = 0; i < 400; i++)
            apply_stimulus(1, 0, ($urandom_range(0, 39) == 0), $urandom_range(0, 1),
                           $urandom_range(0, 1), DW'($urandom));
        for (int i = 0; i < 20; i++) apply_stimulus(1, 0, 0, 1, 0, DW'($urandom));
        apply_stimulus(1, 1, 0, 0, 0, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
